// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: 2-flop synchroniser, per-channel stability
// qualification, press/release edge pulses and an optional long-press pulse.
module debounce_multi #(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = 5000000,
    parameter int HOLD_CNT   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] button_level,
    output logic [N_CH-1:0] button_press,
    output logic [N_CH-1:0] button_release,
    output logic [N_CH-1:0] button_hold
);

    localparam int            CW          = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CNT - 1);
    localparam logic          IDLE_PIN    = (ACTIVE_LOW != 0);

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] w_pressed;

    // Two-flop synchroniser on the raw pins; reset parks them at the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= {N_CH{IDLE_PIN}};
            r_sync2 <= {N_CH{IDLE_PIN}};
        end else begin
            r_sync1 <= button_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          w_accept;

        assign w_accept = (w_pressed[g] != r_level) && (r_cnt == STABLE_LAST);

        // Stability counter and accepted level; edge pulses fire on the toggle edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_accept && !r_level;
                r_release <= w_accept && r_level;
                if (w_pressed[g] == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt   <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign button_level[g]   = r_level;
        assign button_press[g]   = r_press;
        assign button_release[g] = r_release;

        if (HOLD_CNT > 0) begin : g_hold
            localparam int            HW       = $clog2(HOLD_CNT + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CNT);

            logic [HW-1:0] r_hcnt;
            logic          r_hold;

            // Long-press timer: counts pressed cycles, sticks at HOLD_MAX so it fires once
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hcnt <= '0;
                    r_hold <= 1'b0;
                end else if (!r_level) begin
                    r_hcnt <= '0;
                    r_hold <= 1'b0;
                end else if (r_hcnt != HOLD_MAX) begin
                    r_hcnt <= r_hcnt + 1'b1;
                    r_hold <= (r_hcnt == (HOLD_MAX - 1'b1));
                end else begin
                    r_hold <= 1'b0;
                end
            end

            assign button_hold[g] = r_hold;
        end else begin : g_nohold
            assign button_hold[g] = 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (active-low with long-press, active-high
// minimal qualification) checked every cycle against an event-level model.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pin_a = 2'b11;
    logic [1:0] pin_b = 2'b00;
    logic [1:0] lvl_a, prs_a, rel_a, hld_a;
    logic [1:0] lvl_b, prs_b, rel_b, hld_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debounce_multi #(.N_CH(2), .STABLE_CNT(4), .HOLD_CNT(10), .ACTIVE_LOW(1)) u_a (
        .clk(clk), .rst_n(rst_n), .button_in(pin_a),
        .button_level(lvl_a), .button_press(prs_a),
        .button_release(rel_a), .button_hold(hld_a)
    );

    debounce_multi #(.N_CH(2), .STABLE_CNT(1), .HOLD_CNT(0), .ACTIVE_LOW(0)) u_b (
        .clk(clk), .rst_n(rst_n), .button_in(pin_b),
        .button_level(lvl_b), .button_press(prs_b),
        .button_release(rel_b), .button_hold(hld_b)
    );

    // Reference model: a change is accepted once the synchronised (two-edge-old)
    // pressed sample has disagreed with the level on S consecutive edges.
    int stable_n [2] = '{4, 1};
    int hold_n   [2] = '{10, 0};
    bit act_low  [2] = '{1'b1, 1'b0};

    bit seen_last [2][2];
    bit seen_prev [2][2];
    int streak    [2][2];
    bit m_lvl     [2][2];
    int press_at  [2][2];
    int edge_no = 0;
    logic [1:0] e_lvl [2] = '{2'b00, 2'b00};
    logic [1:0] e_prs [2] = '{2'b00, 2'b00};
    logic [1:0] e_rel [2] = '{2'b00, 2'b00};
    logic [1:0] e_hld [2] = '{2'b00, 2'b00};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    seen_last[d][c] = 1'b0;
                    seen_prev[d][c] = 1'b0;
                    streak[d][c]    = 0;
                    m_lvl[d][c]     = 1'b0;
                    press_at[d][c]  = -1;
                end
                e_lvl[d] = 2'b00; e_prs[d] = 2'b00;
                e_rel[d] = 2'b00; e_hld[d] = 2'b00;
            end
        end else begin
            edge_no++;
            for (int d = 0; d < 2; d++) begin
                logic [1:0] pv;
                pv = (d == 0) ? pin_a : pin_b;
                for (int c = 0; c < 2; c++) begin
                    bit now_v;
                    now_v = act_low[d] ? !pv[c] : pv[c];
                    e_prs[d][c] = 1'b0;
                    e_rel[d][c] = 1'b0;
                    e_hld[d][c] = (m_lvl[d][c] && press_at[d][c] >= 0 &&
                                   hold_n[d] > 0 && edge_no - press_at[d][c] == hold_n[d]);
                    if (seen_prev[d][c] != m_lvl[d][c]) streak[d][c]++;
                    else streak[d][c] = 0;
                    if (streak[d][c] == stable_n[d]) begin
                        streak[d][c] = 0;
                        m_lvl[d][c]  = !m_lvl[d][c];
                        if (m_lvl[d][c]) begin
                            e_prs[d][c] = 1'b1;
                            press_at[d][c] = edge_no;
                        end else begin
                            e_rel[d][c] = 1'b1;
                            press_at[d][c] = -1;
                        end
                    end
                    e_lvl[d][c] = m_lvl[d][c];
                    seen_prev[d][c] = seen_last[d][c];
                    seen_last[d][c] = now_v;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("level_a", lvl_a, e_lvl[0]);
        chk("press_a", prs_a, e_prs[0]);
        chk("release_a", rel_a, e_rel[0]);
        chk("hold_a", hld_a, e_hld[0]);
        chk("level_b", lvl_b, e_lvl[1]);
        chk("press_b", prs_b, e_prs[1]);
        chk("release_b", rel_b, e_rel[1]);
        chk("hold_b", hld_b, e_hld[1]);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_n(3);
        chk("rst_level_a", lvl_a, 2'b00);
        chk("rst_press_a", prs_a, 2'b00);
        rst_n = 1'b1;
        wait_n(4);

        // Active-high, single-cycle qualification: level three edges after sampling
        pin_b[0] = 1'b1;
        wait_n(2); chk("b_lat2_level", lvl_b, 2'b00);
        wait_n(1); chk("b_lat3_level", lvl_b, 2'b01);
        chk("b_lat3_press", prs_b, 2'b01);
        pin_b = 2'b00;
        wait_n(5);

        // Clean press on channel 0, then held for a long press
        pin_a[0] = 1'b0;
        wait_n(5); chk("press_e5_level", lvl_a, 2'b00);
        wait_n(1); chk("press_e6_level", lvl_a, 2'b01);
        chk("press_e6_pulse", prs_a, 2'b01);
        wait_n(1); chk("press_e7_pulse", prs_a, 2'b00);
        wait_n(8); chk("hold_e15", hld_a, 2'b00);
        wait_n(1); chk("hold_e16", hld_a, 2'b01);
        wait_n(1); chk("hold_e17", hld_a, 2'b00);
        wait_n(20);

        // Release of channel 0
        pin_a[0] = 1'b1;
        wait_n(5); chk("rel_e5_level", lvl_a, 2'b01);
        wait_n(1); chk("rel_e6_level", lvl_a, 2'b00);
        chk("rel_e6_pulse", rel_a, 2'b01);
        chk("rel_e6_nopress", prs_a, 2'b00);
        wait_n(4);

        // Three-cycle glitch is rejected
        pin_a[0] = 1'b0;
        wait_n(3);
        pin_a[0] = 1'b1;
        wait_n(10); chk("glitch_level", lvl_a, 2'b00);

        // Press released 8 cycles after the press pulse: no hold pulse
        pin_a[0] = 1'b0;
        wait_n(6); chk("short_press", prs_a, 2'b01);
        wait_n(2);
        pin_a[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_n(1); chk("short_nohold", hld_a, 2'b00);
        end

        // Simultaneous press on both channels
        pin_a = 2'b00;
        wait_n(6); chk("dual_press", prs_a, 2'b11);
        chk("dual_level", lvl_a, 2'b11);
        pin_a = 2'b11;
        wait_n(10);

        // Reset mid-press (ch0) and mid-count (ch1); requalify after release
        pin_a[0] = 1'b0;
        wait_n(7); chk("pre_rst_level", lvl_a, 2'b01);
        pin_a[1] = 1'b0;
        wait_n(3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_level", lvl_a, 2'b00);
        chk("async_rst_press", prs_a, 2'b00);
        chk("async_rst_release", rel_a, 2'b00);
        chk("async_rst_hold", hld_a, 2'b00);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(5); chk("post_rst_e5", lvl_a, 2'b00);
        wait_n(1); chk("post_rst_e6", lvl_a, 2'b11);
        chk("post_rst_press", prs_a, 2'b11);
        pin_a = 2'b11;
        wait_n(10);

        // Randomised traffic: short runs first, then long holds, with resets
        for (int i = 0; i < 3000; i++) begin
            int odds;
            odds = (i < 1500) ? 5 : 24;
            wait_n(1);
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, odds) == 0) pin_a[c] = ~pin_a[c];
                if ($urandom_range(0, odds) == 0) pin_b[c] = ~pin_b[c];
            end
            if (i % 1100 == 1000) begin
                #2 rst_n = 1'b0;
                wait_n(1);
                rst_n = 1'b1;
            end
        end
        wait_n(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter STABLE_CNT, default 5000000: consecutive clk cycles a changed input must hold before being accepted (>=1).
REQ-003 SHALL have parameter HOLD_CNT, default 0: cycles of accepted-pressed state before a long-press pulse; 0 disables long-press.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = pin low means pressed; 0 = pin high means pressed.
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port button_in  input  N_CH  raw asynchronous button pins.
REQ-008 SHALL have port button_level  output  N_CH  debounced pressed state, 1 = pressed.
REQ-009 SHALL have port button_press  output  N_CH  one-cycle pulse on accepted press.
REQ-010 SHALL have port button_release  output  N_CH  one-cycle pulse on accepted release.
REQ-011 SHALL have port button_hold  output  N_CH  one-cycle pulse on long press.

Function
REQ-012 SHALL pass each button_in bit through a 2-flop synchroniser, then normalise polarity so that sync value 1 = pressed.
REQ-013 SHALL keep per channel a stability counter sized ceil(log2(STABLE_CNT+1)) bits; no shared counters between channels.
REQ-014 Per channel, on each edge: if sync == button_level, counter SHALL clear to 0.
REQ-015 If sync != button_level and counter < STABLE_CNT-1, counter SHALL increment by 1.
REQ-016 If sync != button_level and counter == STABLE_CNT-1, button_level SHALL toggle and counter SHALL clear on that same edge.
REQ-017 Any return to agreement before acceptance (glitch shorter than STABLE_CNT cycles) SHALL clear the counter with no output change.
REQ-018 Latency: a clean pin change SHALL appear on button_level exactly STABLE_CNT+2 rising edges after the first edge that samples the new pin value.
REQ-019 button_press SHALL be high for exactly the one cycle in which button_level has just gone 0->1; button_release likewise for 1->0; both registered, never asserted together on one channel.
REQ-020 When HOLD_CNT>0, a per-channel hold counter SHALL count cycles while button_level=1, clear when button_level=0, and saturate after firing.
REQ-021 button_hold SHALL pulse for one cycle when the hold counter reaches HOLD_CNT (HOLD_CNT cycles after the press pulse cycle), at most once per press; a release before that SHALL produce no hold pulse.
REQ-022 When HOLD_CNT=0, button_hold SHALL be constant 0 and no hold counter logic shall be generated.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 On rst_n low, synchroniser flops SHALL load the not-pressed pin level, and all counters, button_level, button_press, button_release and button_hold SHALL be 0 immediately, without waiting for clk.
REQ-025 Reset asserted mid-count or mid-press SHALL discard progress; after release the block SHALL treat a still-held button as a new press requiring full STABLE_CNT qualification.

Verification
REQ-026 N_CH=2, STABLE_CNT=4, ACTIVE_LOW=1: drive button_in[0] 1->0 and hold -> button_level[0]=1 and button_press[0]=1 for one cycle, 6 edges after the first sampling edge; channel 1 stays 0.
REQ-027 Same params: pulse button_in[0] low for 3 cycles then high -> button_level, press, release all remain 0.
REQ-028 Same params, pressed channel 0: drive pin high and hold -> button_release[0] one cycle, button_level[0]=0 six edges later; no press pulse.
REQ-029 HOLD_CNT=10: hold press -> button_hold pulse exactly 10 cycles after button_press, once only; release at 8 cycles -> no hold pulse.
REQ-030 Both channels pressed in the same cycle -> button_press=2'b11 in one cycle; assert rst_n low mid-count on another press -> all outputs 0 asynchronously, full 6-edge qualification needed after reset release.
REQ-031 ACTIVE_LOW=0, STABLE_CNT=1: pin 0->1 -> button_level=1 three edges after first sampling edge.
